// File: rtl/banco_reg_pkg.sv
// Shared constants and clear-sequencer state encoding for the banco_reg register file.
package banco_reg_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StDone  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/banco_reg_clr_fsm.sv
// Clear sequencer: sweeps a pointer across every register index, then pulses done for one cycle.
module banco_reg_clr_fsm
  import banco_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ClrReq,
  output logic              ClrBusy,
  output logic              ClrDone,
  output logic              clr_we,
  output logic [ADDR_W-1:0] ptr
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ClrBusy = 1'b0;
    ClrDone = 1'b0;
    clr_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ClrReq) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        ClrBusy = 1'b1;
        clr_we  = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        // All-ones pointer is the last index; it is cleared this cycle.
        if (&ptr_q) state_d = StDone;
      end
      StDone: begin
        ClrDone = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/banco_reg_param.sv
// Parametrised 2-read/1-write register file with async reset, optional zero register and clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining BANCOREG_BYPASS_EN.
module banco_reg_param
  import banco_reg_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegEn,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              ClrReq,
  output logic              ClrBusy,
  output logic              ClrDone
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] ptr;
  logic              wr_ok;

  banco_reg_clr_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk     (clk),
    .rst     (rst),
    .ClrReq  (ClrReq),
    .ClrBusy (ClrBusy),
    .ClrDone (ClrDone),
    .clr_we  (clr_we),
    .ptr     (ptr)
  );

  // Writes are locked out for the whole sweep and never touch a hardwired zero register.
  assign wr_ok = RegEn && !ClrBusy && !(ZERO_REG && (WriteReg == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr_we) begin
      regs[ptr] <= '0;
    end else if (wr_ok) begin
      regs[WriteReg] <= WriteData;
    end
  end

  always_comb begin
    ReadData1 = regs[ReadReg1];
    ReadData2 = regs[ReadReg2];
`ifdef BANCOREG_BYPASS_EN
    if (wr_ok && (ReadReg1 == WriteReg)) ReadData1 = WriteData;
    if (wr_ok && (ReadReg2 == WriteReg)) ReadData2 = WriteData;
`endif
    if (ZERO_REG && (ReadReg1 == '0)) ReadData1 = '0;
    if (ZERO_REG && (ReadReg2 == '0)) ReadData2 = '0;
  end

endmodule

// File: tb/tb_banco_reg_param.sv
// Scoreboard bench for banco_reg_param: two instances (zero register on/off) share all stimulus.
module tb_banco_reg_param;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic        RegEn;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        ClrReq;
  logic [31:0] rd1, rd2, rd1z, rd2z;
  logic        busy, done, busyz, donez;

  banco_reg_param #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .ZERO_REG (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RegEn     (RegEn),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (rd1),
    .ReadData2 (rd2),
    .ClrReq    (ClrReq),
    .ClrBusy   (busy),
    .ClrDone   (done)
  );

  banco_reg_param #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .ZERO_REG (1'b0)
  ) dut_nz (
    .clk       (clk),
    .rst       (rst),
    .RegEn     (RegEn),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (rd1z),
    .ReadData2 (rd2z),
    .ClrReq    (ClrReq),
    .ClrBusy   (busyz),
    .ClrDone   (donez)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] r1, r2, z1, z2;
    logic        busy, done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  string phase = "reset";

  // Reference model: register contents plus "registers still to clear" and "done owed".
  logic [31:0] mem  [DEPTH];
  logic [31:0] memz [DEPTH];
  int          clr_left = 0;
  bit          done_owed = 1'b0;

  task automatic chk(input string nm, input string tag, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s [%s] t=%0t got=%h want=%h", nm, tag, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd1", e.tag, rd1, e.r1);
      chk("rd2", e.tag, rd2, e.r2);
      chk("rd1_nz", e.tag, rd1z, e.z1);
      chk("rd2_nz", e.tag, rd2z, e.z2);
      chk("busy", e.tag, {31'd0, busy}, {31'd0, e.busy});
      chk("done", e.tag, {31'd0, done}, {31'd0, e.done});
      chk("busy_nz", e.tag, {31'd0, busyz}, {31'd0, e.busy});
      chk("done_nz", e.tag, {31'd0, donez}, {31'd0, e.done});
    end
  end

  function automatic logic [31:0] mread(input bit zero, input logic [4:0] a, input bit en,
                                        input logic [4:0] wa, input logic [31:0] wd,
                                        input bit sweeping);
    if (zero && a == 5'd0) return 32'd0;
`ifdef BANCOREG_BYPASS_EN
    if (en && !sweeping && a == wa) return wd;
`endif
    return zero ? mem[a] : memz[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = 32'd0;
      memz[i] = 32'd0;
    end
    clr_left  = 0;
    done_owed = 1'b0;
  endtask

  task automatic step(input bit r, input bit en, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2, input bit cr);
    exp_t e;
    bit   sweeping;
    rst = r; RegEn = en; WriteReg = wa; WriteData = wd;
    ReadReg1 = a1; ReadReg2 = a2; ClrReq = cr;
    if (r) model_reset();
    sweeping = (clr_left > 0);
    e.tag  = phase;
    e.busy = sweeping;
    e.done = done_owed;
    e.r1   = mread(1'b1, a1, en, wa, wd, sweeping);
    e.r2   = mread(1'b1, a2, en, wa, wd, sweeping);
    e.z1   = mread(1'b0, a1, en, wa, wd, sweeping);
    e.z2   = mread(1'b0, a2, en, wa, wd, sweeping);
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (clr_left > 0) begin
      mem[DEPTH - clr_left]  = 32'd0;
      memz[DEPTH - clr_left] = 32'd0;
      clr_left--;
      if (clr_left == 0) done_owed = 1'b1;
    end else begin
      if (en) begin
        if (wa != 5'd0) mem[wa] = wd;
        memz[wa] = wd;
      end
      if (done_owed) done_owed = 1'b0;
      else if (cr) clr_left = DEPTH;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] a1, input logic [4:0] a2);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, a1, a2, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH / 2; i++)
      step(1'b0, 1'b0, 5'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1), 1'b0);
  endtask

  initial begin
    rst = 1'b1; RegEn = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0; ClrReq = 1'b0;
    model_reset();
    @(posedge clk); #1;

    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd1, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd1, 1'b0);
    phase = "post_reset";
    idle(1, 5'd0, 5'd1);

    phase = "write_read";
    step(1'b0, 1'b1, 5'd2, 32'hDEADBEEF, 5'd2, 5'd1, 1'b0);
    idle(1, 5'd2, 5'd2);

    phase = "zero_reg";
    step(1'b0, 1'b1, 5'd0, 32'hCAFEBABE, 5'd0, 5'd2, 1'b0);
    idle(1, 5'd0, 5'd0);

    phase = "fill";
    for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, 5'(i), 32'(i), 5'(i), 5'd0, 1'b0);
    phase = "sweep";
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd20, 1'b1);
    idle(34, 5'd5, 5'd20);
    phase = "after_sweep";
    read_all();

    phase = "write_in_clear";
    for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, 5'(i), 32'(i * 3), 5'd3, 5'd4, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b0, i == 10, 5'd3, 32'h12345678, 5'd3, 5'd1, 1'b0);
    phase = "write_in_done";
    step(1'b0, 1'b1, 5'd3, 32'h12345678, 5'd3, 5'd1, 1'b0);
    idle(2, 5'd3, 5'd1);

    phase = "write_and_req";
    step(1'b0, 1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd3, 1'b1);
    idle(35, 5'd9, 5'd3);

    phase = "reset_mid_sweep";
    for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, 5'(i), ~32'(i), 5'd15, 5'd31, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b1);
    idle(10, 5'd1, 5'd31);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd15, 5'd31, 1'b0);
    idle(3, 5'd15, 5'd31);
    read_all();
    phase = "fresh_sweep";
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b1);
    idle(35, 5'd1, 5'd31);

    phase = "req_held";
    for (int i = 0; i < 72; i++)
      step(1'b0, (i % 3) == 0, 5'(i), 32'(i * 32'h01010101), 5'(i), 5'(i + 1), 1'b1);
    idle(2, 5'd0, 5'd1);

    phase = "bypass";
    step(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0);
    idle(1, 5'd7, 5'd6);
    step(1'b0, 1'b1, 5'd0, 32'h5A5A5A5A, 5'd0, 5'd7, 1'b0);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      bit r, en, cr;
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 1) == 1);
      cr = ($urandom_range(0, 39) == 0);
      step(r, en, 5'($urandom), $urandom, 5'($urandom), 5'($urandom), cr);
    end
    idle(36, 5'd1, 5'd2);
    phase = "final";
    read_all();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
